// File: rtl/md5_arbiter_if.sv
// Bundle of request, word-load, core and result signals shared between the
// MD5 arbiter and its requesters / core / result consumer.
interface md5_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]    req_i;
  logic [NREQ-1:0]    gnt_o;
  logic [NREQ-1:0]    wvalid_i;
  logic [NREQ*32-1:0] wdata_i;
  logic               wready_o;
  logic [479:0]       core_msg_o;
  logic               core_start_o;
  logic               core_done_i;
  logic [127:0]       core_hash_i;
  logic [127:0]       hash_o;
  logic [2:0]         hash_id_o;
  logic               hash_valid_o;
  logic               hash_ready_i;
  logic               err_o;

  // arbiter side
  modport slave (
    input  req_i, wvalid_i, wdata_i, core_done_i, core_hash_i, hash_ready_i,
    output gnt_o, wready_o, core_msg_o, core_start_o, hash_o, hash_id_o,
    hash_valid_o, err_o
  );

  // requester / core / consumer side
  modport master (
    output req_i, wvalid_i, wdata_i, core_done_i, core_hash_i, hash_ready_i,
    input  gnt_o, wready_o, core_msg_o, core_start_o, hash_o, hash_id_o,
    hash_valid_o, err_o
  );
endinterface

// File: rtl/md5_arbiter.sv
// Round-robin arbiter sharing one MD5 core between NREQ requesters.
// A granted requester streams 15 message words, the core is started,
// and its digest is held for the consumer tagged with the requester index.
module md5_arbiter #(
  parameter int NREQ = 4,
  parameter int TMO  = 255
) (
  input  logic          clk_i,
  input  logic          rst_i,
  md5_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, RESULT} state_t;

  state_t            state, state_nxt;
  logic [2:0]        rr_ptr, idx, pick, idx_inc;
  logic [3:0]        pick_sum;
  logic              any_req;
  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic [3:0]        wcnt;
  logic [15:0]       tcnt;
  logic [14:0][31:0] msg;
  logic [127:0]      hash_q;
  logic [2:0]        hash_id_q;
  logic              sel_req, sel_valid;
  logic [31:0]       sel_data;
  logic              timeout;
  logic [NREQ-1:0]   gnt;

  // Round-robin pick: rotate requests so rr_ptr sits at bit 0, take the
  // lowest set bit, and map it back to an absolute index modulo NREQ.
  always_comb begin
    req_dbl  = {bus.req_i, bus.req_i};
    req_rot  = NREQ'(req_dbl >> rr_ptr);
    any_req  = 1'b0;
    pick     = rr_ptr;
    pick_sum = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        any_req  = 1'b1;
        pick_sum = {1'b0, rr_ptr} + 4'(k);
        if (pick_sum >= 4'(NREQ)) pick_sum = pick_sum - 4'(NREQ);
        pick     = pick_sum[2:0];
      end
    end
  end

  // Select the latched requester's request, word-valid and data lanes.
  always_comb begin
    sel_req   = 1'b0;
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (idx == 3'(k)) begin
        sel_req   = bus.req_i[k];
        sel_valid = bus.wvalid_i[k];
        sel_data  = bus.wdata_i[32*k +: 32];
      end
    end
  end

  assign idx_inc = (idx == 3'(NREQ - 1)) ? 3'd0 : idx + 3'd1;
  // Last permitted WAIT cycle: the TMO-th cycle after entering WAIT.
  assign timeout = (tcnt == 16'(TMO - 1));

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; an abort (request drop) beats a final word and
  // core_done beats a coincident timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (any_req) state_nxt = LOAD;
      LOAD: begin
        if (!sel_req)                              state_nxt = IDLE;
        else if (sel_valid && wcnt == 4'd14)       state_nxt = START;
      end
      START:  state_nxt = WAIT;
      WAIT: begin
        if (bus.core_done_i)                       state_nxt = RESULT;
        else if (timeout)                          state_nxt = IDLE;
      end
      RESULT: if (bus.hash_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: index latch, word buffer, timeout counter, digest capture
  // and round-robin pointer advance at the end of each job.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rr_ptr    <= '0;
      idx       <= '0;
      wcnt      <= '0;
      tcnt      <= '0;
      msg       <= '0;
      hash_q    <= '0;
      hash_id_q <= '0;
    end else begin
      case (state)
        IDLE: if (any_req) idx <= pick;
        LOAD: begin
          if (!sel_req) begin
            wcnt   <= '0;
            rr_ptr <= idx_inc;
          end else if (sel_valid) begin
            msg[wcnt] <= sel_data;
            wcnt      <= (wcnt == 4'd14) ? 4'd0 : wcnt + 4'd1;
          end
        end
        START: tcnt <= '0;
        WAIT: begin
          if (bus.core_done_i) begin
            hash_q    <= bus.core_hash_i;
            hash_id_q <= idx;
            tcnt      <= '0;
          end else if (timeout) begin
            rr_ptr <= idx_inc;
            tcnt   <= '0;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        RESULT: if (bus.hash_ready_i) rr_ptr <= idx_inc;
        default: ;
      endcase
    end
  end

  // Grant is a pure decode of registered state and index.
  always_comb begin
    gnt = '0;
    if (state == LOAD || state == START) begin
      for (int k = 0; k < NREQ; k++) gnt[k] = (idx == 3'(k));
    end
  end

  assign bus.gnt_o        = gnt;
  assign bus.wready_o     = (state == LOAD);
  assign bus.core_start_o = (state == START);
  assign bus.core_msg_o   = msg;
  assign bus.hash_o       = hash_q;
  assign bus.hash_id_o    = hash_id_q;
  assign bus.hash_valid_o = (state == RESULT);
  assign bus.err_o        = (state == WAIT) && timeout && !bus.core_done_i;

endmodule

// File: tb/tb_md5_arbiter.sv
// Bench for md5_arbiter: table of jobs driven through a main instance
// (TMO=255) plus hand sequences for abort, timeout/collision (TMO=8 instance)
// and asynchronous reset. Digests are checked through a scoreboard queue.
module tb_md5_arbiter;
  localparam int NREQ = 4;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  md5_arbiter_if #(.NREQ(NREQ)) bus ();
  md5_arbiter_if #(.NREQ(NREQ)) bus_t ();

  md5_arbiter #(.NREQ(NREQ), .TMO(255)) dut   (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));
  md5_arbiter #(.NREQ(NREQ), .TMO(8))   dut_t (.clk_i(clk_i), .rst_i(rst_i), .bus(bus_t));

  typedef struct {
    logic [3:0]   req;
    int           exp_id;
    int           dly;
    int           hold;
    bit           stray;
    bit           drop;
    bit           rst;
    logic [31:0]  base;
    logic [127:0] hash;
  } job_t;

  typedef struct {
    logic [127:0] hash;
    logic [2:0]   id;
  } sb_t;

  job_t tbl[9];
  sb_t  sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   start_cnt = 0;

  always @(negedge clk_i) if (bus.core_start_o) start_cnt++;

  task automatic chk(input bit ok, input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic run_job(input job_t r);
    int c;
    bit got, bad;
    logic [3:0] eg;
    logic [479:0] em;
    sb_t e;
    eg = 4'b0001 << r.exp_id;
    for (int j = 0; j < 15; j++) em[32*j +: 32] = r.base + 32'(j);
    e.hash = '0;
    e.id = '0;
    tick();
    bus.hash_ready_i = 1'b0;
    bus.req_i = r.req;
    c = 0;
    @(negedge clk_i);
    chk(bus.gnt_o == 0 && !bus.hash_valid_o, "idle", 128'({bus.gnt_o, bus.hash_valid_o}), 0);
    got = 0;
    for (int t = 0; t < 8 && !got; t++) begin
      tick(); c++;
      @(negedge clk_i);
      got = (bus.gnt_o != 0);
    end
    chk(got && c == 1, "gnt_latency", 128'(c), 1);
    chk(bus.gnt_o == eg, "gnt", 128'(bus.gnt_o), 128'(eg));
    bad = 0;
    for (int j = 0; j < 15; j++) begin
      tick(); c++;
      bus.core_done_i = r.stray && j == 3;
      bus.core_hash_i = ~r.hash;
      bus.wvalid_i = '1;
      for (int k = 0; k < NREQ; k++)
        bus.wdata_i[32*k +: 32] = (k == r.exp_id) ? r.base + 32'(j) : 32'hDEAD0000 + 32'(j);
      @(negedge clk_i);
      bad |= !bus.wready_o || bus.core_start_o || bus.gnt_o != eg;
    end
    chk(!bad, "load", 128'(bad), 0);
    tick(); c++;
    bus.wvalid_i = '0;
    bus.core_done_i = 1'b0;
    if (r.drop) bus.req_i = '0;
    @(negedge clk_i);
    chk(bus.core_start_o && c == 17, "start_latency", 128'(c), 17);
    chk(!bus.wready_o && bus.gnt_o == eg, "start_gnt", 128'({bus.wready_o, bus.gnt_o}), 128'(eg));
    chk(bus.core_msg_o == em, "core_msg", bus.core_msg_o[127:0], em[127:0]);
    if (r.rst) begin
      tick(); tick();
      @(negedge clk_i);
      #2 rst_i = 1'b0;
      #1;
      chk({bus.gnt_o, bus.wready_o, bus.core_start_o, bus.hash_valid_o, bus.err_o} == 0,
          "rst_ctrl", 128'({bus.gnt_o, bus.wready_o, bus.core_start_o, bus.hash_valid_o, bus.err_o}), 0);
      chk(bus.hash_o == 0 && bus.hash_id_o == 0, "rst_hash", bus.hash_o, 0);
      chk(bus.core_msg_o == 0, "rst_msg", bus.core_msg_o[127:0], 0);
      bus.req_i = '0;
      #1 rst_i = 1'b1;
      return;
    end
    bad = 0;
    for (int d = 1; d <= r.dly; d++) begin
      tick();
      bus.core_done_i = (d == r.dly);
      if (d == r.dly) begin
        bus.core_hash_i = r.hash;
        sb.push_back('{r.hash, 3'(r.exp_id)});
      end
      @(negedge clk_i);
      bad |= bus.core_start_o || bus.err_o || bus.hash_valid_o;
    end
    chk(!bad, "wait", 128'(bad), 0);
    tick();
    bus.core_done_i = 1'b0;
    bus.core_hash_i = '0;
    @(negedge clk_i);
    chk(bus.hash_valid_o, "hash_valid", 128'(bus.hash_valid_o), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk(bus.hash_o == e.hash, "hash", bus.hash_o, e.hash);
      chk(bus.hash_id_o == e.id, "hash_id", 128'(bus.hash_id_o), 128'(e.id));
    end else begin
      chk(1'b0, "scoreboard_empty", 0, 1);
    end
    if (r.hold > 0) begin
      bad = 0;
      for (int h = 0; h < r.hold; h++) begin
        tick();
        @(negedge clk_i);
        bad |= !bus.hash_valid_o || bus.hash_o != e.hash || bus.gnt_o != 0;
      end
      chk(!bad, "backpressure", 128'(bad), 0);
    end
    tick();
    bus.hash_ready_i = 1'b1;
    @(negedge clk_i);
  endtask

  // Push one 15-word job through the TMO=8 instance up to its start pulse.
  task automatic load_t(input logic [31:0] base);
    tick();
    bus_t.req_i = 4'b0001;
    bus_t.hash_ready_i = 1'b0;
    tick();
    @(negedge clk_i);
    chk(bus_t.gnt_o == 4'b0001, "t_gnt", 128'(bus_t.gnt_o), 1);
    for (int j = 0; j < 15; j++) begin
      tick();
      bus_t.wvalid_i = 4'b0001;
      bus_t.wdata_i[31:0] = base + 32'(j);
    end
    tick();
    bus_t.wvalid_i = '0;
    bus_t.req_i = '0;
    @(negedge clk_i);
    chk(bus_t.core_start_o, "t_start", 128'(bus_t.core_start_o), 1);
  endtask

  initial begin
    int snap;
    bit bad;
    tbl[0] = '{4'b1111, 0,   3,  0, 0, 0, 0, 32'h100, 128'h11111111222222223333333344444444};
    tbl[1] = '{4'b1111, 1,   1,  0, 0, 0, 0, 32'h200, 128'hA5A5A5A55A5A5A5AA5A5A5A55A5A5A5A};
    tbl[2] = '{4'b1111, 2,  10, 20, 0, 0, 0, 32'h300, 128'hDEADBEEFCAFEF00D0123456789ABCDEF};
    tbl[3] = '{4'b1111, 3, 255,  0, 0, 0, 0, 32'h400, 128'hFFFFFFFF00000000FFFFFFFF00000001};
    tbl[4] = '{4'b1111, 0,   6,  0, 0, 0, 0, 32'h500, 128'h0F0F0F0F0F0F0F0FF0F0F0F0F0F0F0F0};
    tbl[5] = '{4'b0001, 0,  10,  0, 1, 1, 0, 32'h000, 128'h0123456789ABCDEF0123456789ABCDEF};
    tbl[6] = '{4'b1001, 3,   2,  0, 0, 0, 0, 32'h700, 128'h13579BDF2468ACE013579BDF2468ACE0};
    tbl[7] = '{4'b0010, 1,   5,  0, 0, 0, 1, 32'h800, 128'h0};
    tbl[8] = '{4'b0011, 0,   4,  0, 0, 0, 0, 32'h900, 128'hFEDCBA9876543210FEDCBA9876543210};

    bus.req_i = '0;   bus.wvalid_i = '0;   bus.wdata_i = '0;
    bus.core_done_i = 1'b0; bus.core_hash_i = '0; bus.hash_ready_i = 1'b0;
    bus_t.req_i = '0; bus_t.wvalid_i = '0; bus_t.wdata_i = '0;
    bus_t.core_done_i = 1'b0; bus_t.core_hash_i = '0; bus_t.hash_ready_i = 1'b0;

    #12;
    chk({bus.gnt_o, bus.wready_o, bus.core_start_o, bus.hash_valid_o, bus.err_o,
         bus.hash_o, bus.hash_id_o, bus.core_msg_o} == 0, "reset_state", bus.hash_o, 0);
    rst_i = 1'b1;

    for (int i = 0; i < 6; i++) run_job(tbl[i]);

    // Abort: requester 2 drops after 7 words; requester 3 is then next.
    snap = start_cnt;
    tick();
    bus.hash_ready_i = 1'b0;
    bus.req_i = 4'b0100;
    @(negedge clk_i);
    chk(bus.gnt_o == 0, "ab_idle", 128'(bus.gnt_o), 0);
    tick();
    @(negedge clk_i);
    chk(bus.gnt_o == 4'b0100, "ab_gnt", 128'(bus.gnt_o), 4);
    for (int j = 0; j < 7; j++) begin
      tick();
      if (j == 0) bus.req_i = 4'b1100;
      bus.wvalid_i = 4'b0100;
      bus.wdata_i[95:64] = 32'hAB00 + 32'(j);
    end
    tick();
    bus.wvalid_i = '0;
    bus.req_i = 4'b1001;
    @(negedge clk_i);
    run_job(tbl[6]);
    chk(start_cnt == snap + 1, "ab_no_start", 128'(start_cnt), 128'(snap + 1));
    tick();
    bus.hash_ready_i = 1'b0;
    bus.req_i = '0;

    // Timeout with TMO=8: err on the 8th cycle after start, nothing earlier.
    load_t(32'h1000);
    bad = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      @(negedge clk_i);
      if (k < 8) bad |= bus_t.err_o;
      else chk(bus_t.err_o, "t_err", 128'(bus_t.err_o), 1);
      bad |= bus_t.hash_valid_o;
    end
    chk(!bad, "t_err_early", 128'(bad), 0);
    tick();
    @(negedge clk_i);
    chk(!bus_t.err_o && !bus_t.hash_valid_o && bus_t.gnt_o == 0, "t_idle",
        128'({bus_t.err_o, bus_t.hash_valid_o, bus_t.gnt_o}), 0);

    // Collision: done on the timeout cycle wins.
    load_t(32'h2000);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 8) begin
        bus_t.core_done_i = 1'b1;
        bus_t.core_hash_i = 128'hC0111DE0C0111DE0C0111DE0C0111DE0;
      end
      @(negedge clk_i);
      if (k == 8) chk(!bus_t.err_o, "coll_err", 128'(bus_t.err_o), 0);
    end
    tick();
    bus_t.core_done_i = 1'b0;
    bus_t.core_hash_i = '0;
    @(negedge clk_i);
    chk(bus_t.hash_valid_o && bus_t.hash_o == 128'hC0111DE0C0111DE0C0111DE0C0111DE0,
        "coll_result", bus_t.hash_o, 128'hC0111DE0C0111DE0C0111DE0C0111DE0);
    tick();
    bus_t.hash_ready_i = 1'b1;
    tick();
    bus_t.hash_ready_i = 1'b0;

    // Asynchronous reset mid-WAIT, then a fresh job from a reset pointer.
    run_job(tbl[7]);
    run_job(tbl[8]);
    tick();
    bus.hash_ready_i = 1'b0;
    bus.req_i = '0;
    @(negedge clk_i);
    chk(!bus.hash_valid_o, "final_clear", 128'(bus.hash_valid_o), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/md5_arbiter.md
MD5_ARBITER -- requirements
Module: md5_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one MD5 core (2..8).
REQ-002 Parameter TMO, default 255: cycles to wait for core_done_i before aborting (1..65535).
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-low.
REQ-005 req_i  input  NREQ  per-requester request; bit k = requester k.
REQ-006 gnt_o  output  NREQ  one-hot grant, or all-zero.
REQ-007 wvalid_i  input  NREQ  per-requester message-word valid.
REQ-008 wdata_i  input  NREQ*32  per-requester word; requester k at bits [32k+31:32k].
REQ-009 wready_o  output  1  word accepted from the granted requester this cycle.
REQ-010 core_msg_o  output  480  15 loaded words; word j at bits [32j+31:32j].
REQ-011 core_start_o  output  1  one-cycle start pulse to the core.
REQ-012 core_done_i  input  1  core finished; core_hash_i valid this cycle.
REQ-013 core_hash_i  input  128  core digest.
REQ-014 hash_o  output  128  captured digest.
REQ-015 hash_id_o  output  3  index of the requester owning hash_o.
REQ-016 hash_valid_o  output  1  hash_o/hash_id_o valid; held until hash_ready_i.
REQ-017 hash_ready_i  input  1  consumer accepts the result.
REQ-018 err_o  output  1  one-cycle pulse on timeout.

Function
REQ-019 FSM states: IDLE, LOAD, START, WAIT, RESULT; exactly one active.
REQ-020 IDLE: gnt_o=0; if any req_i bit is set, grant the first set bit found searching upward (with wrap) from rr_ptr, latch the index, and go to LOAD next cycle.
REQ-021 LOAD: gnt_o is one-hot on the latched index; wready_o=1.
REQ-022 LOAD: on each cycle with wvalid_i[idx]=1, write wdata_i[idx] into word[wcnt] and increment wcnt (0..14).
REQ-023 LOAD: acceptance of word 14 moves to START; wcnt returns to 0.
REQ-024 LOAD: if req_i[idx] falls before word 14, go to IDLE with no core_start_o and wcnt=0; rr_ptr=idx+1 mod NREQ.
REQ-025 START: core_start_o=1 for exactly one cycle, gnt_o held, wready_o=0, then go to WAIT.
REQ-026 core_msg_o is stable from the START cycle until the next LOAD write.
REQ-027 WAIT: tcnt increments every cycle from 0. core_done_i=1 captures core_hash_i into hash_o and idx into hash_id_o, then goes to RESULT.
REQ-028 WAIT: if tcnt reaches TMO without done, pulse err_o for one cycle, go to IDLE, and set rr_ptr=idx+1.
REQ-029 If core_done_i and the timeout occur in the same cycle, done wins and err_o stays 0.
REQ-030 RESULT: hash_valid_o=1 with hash_o/hash_id_o stable. hash_ready_i=1 moves to IDLE, clears hash_valid_o next cycle, and sets rr_ptr=idx+1.
REQ-031 core_done_i outside WAIT is ignored; req_i changes after START do not abort.
REQ-032 Request-to-start latency with words presented back-to-back: grant 1 cycle after req_i, words 15 cycles, core_start_o on the next cycle.
REQ-033 rr_ptr, idx and the 3-bit hash_id_o zero-extend when NREQ<8; wrap is modulo NREQ.
REQ-034 gnt_o, wready_o and core_start_o are registered-state decodes, with no combinational path from req_i.

Reset
REQ-035 rst_i=0 asynchronously forces: IDLE, rr_ptr=0, wcnt=0, tcnt=0, gnt_o=0, wready_o=0, core_start_o=0, hash_valid_o=0, err_o=0, hash_o=0, hash_id_o=0, core_msg_o=0.
REQ-036 Reset in any state, including mid-LOAD or WAIT, discards the operation; after release the block waits in IDLE for a request.

Verification
REQ-037 Single job: req_i=0001, then words 0x00000000..0x0000000E on consecutive cycles; core_done_i after 10 cycles with hash 0x0123..CDEF -> gnt_o=0001 at cycle 1, core_start_o at cycle 17, hash_valid_o=1 with hash_id_o=0.
REQ-038 Fairness: req_i=1111 held continuously, with done returned and results acked -> grant order 0,1,2,3,0.
REQ-039 Abort: requester 2 drops req after 7 words -> no core_start_o, return to IDLE, next grant goes to requester 3 if it is requesting.
REQ-040 Timeout: TMO=8 with core_done_i never asserted -> err_o pulse 8 cycles after core_start_o, then IDLE, with hash_valid_o remaining 0.
REQ-041 Backpressure and collision: hash_ready_i held 0 for 20 cycles -> hash_o stable and no new grant; a separate case with done on the timeout cycle -> RESULT, err_o=0.
REQ-042 Async reset: rst_i=0 mid-WAIT, asserted between clock edges -> all outputs zero immediately, then a fresh job completes normally.
